// File: rtl/serial_group_checker.sv
// serial_group_checker: serially checks one group of N cell values for being a permutation of 1..N.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              pulse: begin (or restart) a group
//   num, num_valid     cell value and its qualifier
//   num_ready          high while collecting values
//   done               one-cycle pulse when the group result is valid
//   legal              group is a permutation of 1..N
//   range_err, dup_err value out of 1..N / in-range value repeated (sticky)
//   bad_index          arrival index of the first offending value
//   sum                sum of all accepted values
module serial_group_checker #(
  parameter int N  = 9,
  parameter int W  = $clog2(N + 1),
  parameter int IW = $clog2(N),
  parameter int SW = W + $clog2(N) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  num,
  input  logic          num_valid,
  output logic          num_ready,
  output logic          done,
  output logic          legal,
  output logic          range_err,
  output logic          dup_err,
  output logic [IW-1:0] bad_index,
  output logic [SW-1:0] sum
);
  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
  localparam logic [W-1:0]  MAXV = W'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state, state_n;
  logic [N-1:0] seen, oh;
  logic [IW-1:0] count;
  logic take, last, bad, dup, err;
  always_comb begin
    // start wins over a same-cycle transfer, which is discarded
    take = state == COLLECT && num_valid && !start;
    last = take && count == LAST;
    bad = num == '0 || num > MAXV;
    // num == 0 wraps the shift amount past N-1, giving an all-zero mask
    oh = {{(N-1){1'b0}}, 1'b1} << (num - 1'b1);
    dup = !bad && |(seen & oh);
    err = bad || dup;
    state_n = start ? COLLECT : last ? REPORT : state == REPORT ? IDLE : state;
    num_ready = state == COLLECT;
    done = state == REPORT;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or posedge reset) begin
    if (reset || start) begin
      seen <= '0;
      count <= '0;
      sum <= '0;
      range_err <= 1'b0;
      dup_err <= 1'b0;
      bad_index <= '0;
      legal <= 1'b0;
    end else if (take) begin
      sum <= sum + SW'(num);
      if (bad) range_err <= 1'b1;
      else if (dup) dup_err <= 1'b1;
      else seen <= seen | oh;
      if (err && !range_err && !dup_err) bad_index <= count;
      count <= count + 1'b1;
      // legal is latched with the final transfer so it is valid alongside done
      if (last) legal <= !(range_err || dup_err || err);
    end
  end
endmodule

// File: tb/tb_serial_group_checker.sv
// tb_serial_group_checker: randomized self-checking bench for N=9 and N=4 checker instances.
module tb_serial_group_checker;
  logic clock = 0, reset = 1;
  logic start_a = 0, valid_a = 0, start_b = 0, valid_b = 0;
  logic [3:0] num_a = 0;
  logic [2:0] num_b = 0;
  logic ready_a, done_a, legal_a, rerr_a, derr_a, ready_b, done_b, legal_b, rerr_b, derr_b;
  logic [3:0] bidx_a;
  logic [1:0] bidx_b;
  logic [8:0] sum_a;
  logic [5:0] sum_b;
  int n_checks = 0, n_fail = 0;

  serial_group_checker #(.N(9)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .num(num_a), .num_valid(valid_a),
    .num_ready(ready_a), .done(done_a), .legal(legal_a), .range_err(rerr_a),
    .dup_err(derr_a), .bad_index(bidx_a), .sum(sum_a)
  );
  serial_group_checker #(.N(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .num(num_b), .num_valid(valid_b),
    .num_ready(ready_b), .done(done_b), .legal(legal_b), .range_err(rerr_b),
    .dup_err(derr_b), .bad_index(bidx_b), .sum(sum_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit sel, input bit v, input int x);
    if (sel) begin valid_b = v; num_b = x[2:0]; end
    else begin valid_a = v; num_a = x[3:0]; end
  endtask

  // Reference: legal means the sorted group is exactly 1..n; errors found by counting occurrences.
  task automatic model(input int v[$], input int n, output int lg, output int re,
                       output int de, output int bi, output int sm);
    int occ[16];
    int s[$];
    bit first;
    lg = 1; re = 0; de = 0; bi = 0; sm = 0; first = 1;
    foreach (occ[k]) occ[k] = 0;
    foreach (v[i]) begin
      sm += v[i];
      if (v[i] < 1 || v[i] > n) begin
        re = 1;
        if (first) begin bi = i; first = 0; end
      end else begin
        if (occ[v[i]] > 0) begin
          de = 1;
          if (first) begin bi = i; first = 0; end
        end
        occ[v[i]]++;
      end
    end
    s = v;
    s.sort();
    foreach (s[i]) if (s[i] != i + 1) lg = 0;
  endtask

  // gaps: 0 none, 1 random, 2 on every other cycle; full=0 feeds without expecting done
  task automatic feed(input bit sel, input int v[$], input int gaps, input bit full, input string nm);
    bit early;
    int lg, re, de, bi, sm;
    early = 0;
    @(negedge clock);
    if (sel) start_b = 1; else start_a = 1;
    set_in(sel, 1, 1);
    @(negedge clock);
    start_a = 0; start_b = 0;
    check({nm, "_ready"}, sel ? ready_b : ready_a, 1);
    foreach (v[i]) begin
      if (gaps == 2 || (gaps == 1 && $urandom_range(1) == 1)) begin
        set_in(sel, 0, $urandom_range(0, 15));
        @(negedge clock);
        early |= sel ? done_b : done_a;
      end
      set_in(sel, 1, v[i]);
      @(negedge clock);
      if (i < v.size() - 1) early |= sel ? done_b : done_a;
    end
    set_in(sel, 0, 0);
    check({nm, "_early_done"}, early, 0);
    if (full) begin
      model(v, sel ? 4 : 9, lg, re, de, bi, sm);
      check({nm, "_done"}, sel ? done_b : done_a, 1);
      check({nm, "_legal"}, sel ? legal_b : legal_a, lg);
      check({nm, "_range_err"}, sel ? rerr_b : rerr_a, re);
      check({nm, "_dup_err"}, sel ? derr_b : derr_a, de);
      check({nm, "_bad_index"}, sel ? bidx_b : bidx_a, bi);
      check({nm, "_sum"}, sel ? sum_b : sum_a, sm);
      check({nm, "_ready_report"}, sel ? ready_b : ready_a, 0);
      @(negedge clock);
      check({nm, "_done_pulse"}, sel ? done_b : done_a, 0);
      check({nm, "_hold_legal"}, sel ? legal_b : legal_a, lg);
      check({nm, "_hold_sum"}, sel ? sum_b : sum_a, sm);
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, "_ready"}, ready_a, 0);
    check({nm, "_done"}, done_a, 0);
    check({nm, "_legal"}, legal_a, 0);
    check({nm, "_range_err"}, rerr_a, 0);
    check({nm, "_dup_err"}, derr_a, 0);
    check({nm, "_bad_index"}, bidx_a, 0);
    check({nm, "_sum"}, sum_a, 0);
  endtask

  initial begin
    int q[$];
    repeat (2) @(negedge clock);
    check_cleared("reset_a");
    check("reset_ready_b", ready_b, 0);
    reset = 0;
    @(negedge clock);
    check("idle_ready", ready_a, 0);
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};          feed(0, q, 0, 1, "perm9");
    q = '{1, 1, 3, 4, 5, 6, 7, 8, 9};          feed(0, q, 0, 1, "dup9");
    q = '{0, 2, 3, 4, 5, 6, 7, 8, 9};          feed(0, q, 0, 1, "zero9");
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 10};         feed(0, q, 0, 1, "over9");
    q = '{9, 8, 7, 6, 5, 4, 3, 2, 1};          feed(0, q, 2, 1, "gaps9");
    q = '{3, 1, 4, 2};                         feed(0, q, 0, 0, "part9");
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};          feed(0, q, 0, 1, "restart9");
    q = '{3, 1, 4, 2};                         feed(0, q, 1, 0, "part9r");
    reset = 1;
    @(negedge clock);
    reset = 0;
    check_cleared("midreset");
    repeat (12) @(negedge clock);
    check("midreset_no_done", done_a, 0);
    q = '{2, 4, 1, 3};                         feed(1, q, 0, 1, "perm4");
    q = '{2, 5, 5, 1};                         feed(1, q, 0, 1, "range4");
    q = '{4, 4, 1, 2};                         feed(1, q, 1, 1, "dup4");
    for (int r = 0; r < 10; r++) begin
      q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      q.shuffle();
      if (r % 2 == 1) for (int i = 0; i < 9; i++) if ($urandom_range(3) == 0) q[i] = $urandom_range(0, 15);
      feed(0, q, 1, 1, "rand9");
      q = '{1, 2, 3, 4};
      q.shuffle();
      if (r % 2 == 1) for (int i = 0; i < 4; i++) if ($urandom_range(2) == 0) q[i] = $urandom_range(0, 7);
      feed(1, q, 1, 1, "rand4");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_group_checker.md
Name: serial_group_checker

Overview:
- Sequential, parametrised successor to the combinational nine-cell legality check.
- Accepts one group of N cell values serially over a valid/ready handshake and checks every value is in range 1..N.
- Checks that no value repeats (a permutation of 1..N), reports the first offending position, and keeps a running sum for downstream equal-sum comparison.
- Sits between the board-entry sequencer and the board-level result logic; one instance per row, column or box stream.

Parameters:
- N, 9, number of cells per group and maximum legal value (2..15).
- W, $clog2(N+1), width of one cell value (derived, must not be overridden).
- IW, $clog2(N), width of the cell index (derived).
- SW, W+$clog2(N)+1, width of the running sum (derived; holds N*(2**W-1) without overflow).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  1-cycle pulse: begin a new group
- num  in  W  cell value
- num_valid  in  1  num presented this cycle
- num_ready  out  1  checker accepts num this cycle
- done  out  1  1-cycle pulse: group result valid
- legal  out  1  group is a permutation of 1..N
- range_err  out  1  some value was 0 or >N
- dup_err  out  1  some in-range value repeated
- bad_index  out  IW  index (0-based arrival order) of first offending value
- sum  out  SW  sum of all N accepted values

Behaviour:
- Reset (async, active-high): state=IDLE; seen mask, count, sum, range_err, dup_err, bad_index=0; legal=0; done=0; num_ready=0.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE: num_ready=0; num ignored. start -> clear mask, count, sum, error flags, bad_index and legal; go to COLLECT next cycle.
- COLLECT: num_ready=1. A transfer occurs when num_valid && num_ready; num_valid may drop any cycle (gaps allowed).
- On each transfer:
  - sum += num (zero-extended).
  - If num==0 or num>N: set range_err (sticky).
  - Else if seen[num-1]==1: set dup_err (sticky).
  - Else: seen[num-1] := 1.
  - On the first error of the group (range or dup), latch bad_index := count. Later errors do not change it.
  - count += 1.
- Transfer with count==N-1: go to REPORT on the next edge; num_ready is 0 from that cycle.
- REPORT: lasts exactly one cycle.
  - done=1.
  - legal = !range_err && !dup_err (equivalently, seen mask all ones).
  - Go to IDLE.
- Results hold until the next start or reset. Latency: done rises one cycle after the clock edge of the Nth transfer.
- start while in COLLECT: abandon the group, clear as above, stay in COLLECT. A same-cycle transfer is discarded.
- start while in REPORT: done still pulses this cycle; then enter COLLECT with cleared state (results cleared on that edge).
- Reset mid-group: immediate return to IDLE; no done pulse.
- With no error, bad_index=0 and both error flags are 0.
- legal, range_err, dup_err, bad_index and sum are registered outputs (no combinational path from num).
- Sum has no wrap; width covers the worst case.

Test Plan:
- N=9; start; values 1..9 with no gaps -> done one cycle after 9th transfer; legal=1, range_err=0, dup_err=0, bad_index=0, sum=45.
- N=9; values 1,1,3,4,5,6,7,8,9 -> dup_err=1, range_err=0, legal=0, bad_index=1, sum=44.
- N=9; values 0,2,3,4,5,6,7,8,9 then separately 1..8,10 -> range_err=1, legal=0; bad_index=0 and 8 respectively; sums 44 and 46.
- N=9; 9,8,7,...,1 with num_valid low on alternate cycles and junk num while low -> gaps ignored, legal=1, sum=45, done after 9th transfer only.
- N=9; 4 values accepted, then start pulse, then 1..9 -> earlier values discarded, legal=1, sum=45. Repeat with a reset pulse after 4 values -> IDLE, num_ready=0, no done, all outputs 0.
- N=4 instance; values 2,4,1,3 -> legal=1, sum=10. Values 2,5,5,1 -> range_err=1, dup_err=0 (5 is out of range, not a duplicate), bad_index=1.
